// File: rtl/btn_event_arbiter.sv
// Button-bank controller: shared filter clock-enable tick, per-button pending/overflow
// capture, and a round-robin arbiter offering one press at a time over valid/ready.
module btn_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int CE_DIV = 50000,
  parameter int ID_W   = $clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             CE_O,
  input  logic [N_BTN-1:0] BTN_CEO_I,
  input  logic             CLR_OVF,
  output logic             EVT_VALID,
  output logic [ID_W-1:0]  EVT_ID,
  input  logic             EVT_READY,
  output logic [N_BTN-1:0] PEND_O,
  output logic [N_BTN-1:0] OVF_O
);

  localparam int              TW   = $clog2(CE_DIV);
  localparam logic [TW-1:0]   TMAX = TW'(CE_DIV - 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_last;
  logic [TW-1:0]     r_tcnt;

  logic [N_BTN-1:0]  w_acc;
  logic [N_BTN-1:0]  w_ovf_set;
  logic [ID_W-1:0]   w_sel;
  logic [ID_W-1:0]   w_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tcnt <= '0;
      CE_O   <= 1'b0;
    end else if (!EN) begin
      r_tcnt <= '0;
      CE_O   <= 1'b0;
    end else begin
      CE_O   <= (r_tcnt == TMAX);
      r_tcnt <= (r_tcnt == TMAX) ? '0 : r_tcnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_acc[i] = EVT_VALID & EVT_READY & (EVT_ID == ID_W'(i));
    end
  end

  // A press landing on an already-pending, not-being-accepted flag is an overflow.
  assign w_ovf_set = BTN_CEO_I & PEND_O & ~w_acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PEND_O <= '0;
      OVF_O  <= '0;
    end else begin
      PEND_O <= BTN_CEO_I | (PEND_O & ~w_acc);
      OVF_O  <= w_ovf_set | (OVF_O & ~{N_BTN{CLR_OVF}});
    end
  end

  // Scan from the farthest offset down so the nearest pending index after r_last wins.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int off = N_BTN; off >= 1; off--) begin
      w_idx = ID_W'((int'(r_last) + off) % N_BTN);
      if (PEND_O[w_idx]) w_sel = w_idx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_last    <= ID_W'(N_BTN - 1);
      EVT_VALID <= 1'b0;
      EVT_ID    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|PEND_O) begin
            EVT_ID    <= w_sel;
            EVT_VALID <= 1'b1;
            r_state   <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (EVT_READY) begin
            r_last    <= EVT_ID;
            EVT_VALID <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          EVT_VALID <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter (N_BTN=4, CE_DIV=5).
module tb_btn_event_arbiter;
  localparam int N_BTN  = 4;
  localparam int CE_DIV = 5;
  localparam int ID_W   = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic             CE_O;
  logic [N_BTN-1:0] BTN_CEO_I;
  logic             CLR_OVF;
  logic             EVT_VALID;
  logic [ID_W-1:0]  EVT_ID;
  logic             EVT_READY;
  logic [N_BTN-1:0] PEND_O;
  logic [N_BTN-1:0] OVF_O;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  btn_event_arbiter #(.N_BTN(N_BTN), .CE_DIV(CE_DIV), .ID_W(ID_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .CE_O      (CE_O),
    .BTN_CEO_I (BTN_CEO_I),
    .CLR_OVF   (CLR_OVF),
    .EVT_VALID (EVT_VALID),
    .EVT_ID    (EVT_ID),
    .EVT_READY (EVT_READY),
    .PEND_O    (PEND_O),
    .OVF_O     (OVF_O)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; EN = 1'b0; BTN_CEO_I = '0; CLR_OVF = 1'b0; EVT_READY = 1'b0;
    step(); step();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; EN = 1'b0; BTN_CEO_I = '0; CLR_OVF = 1'b0; EVT_READY = 1'b0;
    #1;
    total++;
    if ({CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O} !== '0) begin
      bad++; $display("FAIL reset_async outs=%b want 0", {CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O});
    end
    step(); step();
    RST = 1'b1;
    step(); step();
    total++;
    if ({CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O} !== '0) begin
      bad++; $display("FAIL reset_idle outs=%b want 0", {CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O});
    end
  endtask

  task automatic test_tick();
    RST = 1'b0; EN = 1'b1; BTN_CEO_I = '0; CLR_OVF = 1'b0; EVT_READY = 1'b0;
    step(); step();
    RST = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      step();
      total++;
      if (CE_O !== ((c % CE_DIV) == 0)) begin
        bad++; $display("FAIL tick_run cycle=%0d ce=%b want %b", c, CE_O, (c % CE_DIV) == 0);
      end
    end
    EN = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      total++;
      if (CE_O !== 1'b0) begin
        bad++; $display("FAIL tick_disabled cycle=%0d ce=%b want 0", c, CE_O);
      end
    end
    EN = 1'b1;
    for (int c = 1; c <= CE_DIV; c++) begin
      step();
      total++;
      if (CE_O !== (c == CE_DIV)) begin
        bad++; $display("FAIL tick_reenable cycle=%0d ce=%b want %b", c, CE_O, c == CE_DIV);
      end
    end
    EN = 1'b0;
  endtask

  task automatic test_single_press();
    do_reset();
    EVT_READY = 1'b1;
    BTN_CEO_I = 4'b0100;
    step();
    BTN_CEO_I = '0;
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0100) begin
      bad++; $display("FAIL press_pend valid=%b pend=%b want 0/0100", EVT_VALID, PEND_O);
    end
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_10) begin
      bad++; $display("FAIL press_offer valid=%b id=%0d want 1/2", EVT_VALID, EVT_ID);
    end
    step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL press_done valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] exp_id;
    do_reset();
    EVT_READY = 1'b1;
    BTN_CEO_I = 4'b1111;
    step();
    BTN_CEO_I = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (k % 2 == 0) begin
        exp_id = ID_W'(k / 2);
        if ({EVT_VALID, EVT_ID} !== {1'b1, exp_id}) begin
          bad++; $display("FAIL rr_grant k=%0d valid=%b id=%0d want 1/%0d", k, EVT_VALID, EVT_ID, exp_id);
        end
      end else if (EVT_VALID !== 1'b0) begin
        bad++; $display("FAIL rr_gap k=%0d valid=%b want 0", k, EVT_VALID);
      end
    end
    total++;
    if (PEND_O !== 4'b0000) begin
      bad++; $display("FAIL rr_drained pend=%b want 0000", PEND_O);
    end
    BTN_CEO_I = 4'b1001;
    step();
    BTN_CEO_I = '0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_00) begin
      bad++; $display("FAIL rr_wrap_first valid=%b id=%0d want 1/0", EVT_VALID, EVT_ID);
    end
    step(); step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_11) begin
      bad++; $display("FAIL rr_wrap_second valid=%b id=%0d want 1/3", EVT_VALID, EVT_ID);
    end
    step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL rr_wrap_done valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    BTN_CEO_I = 4'b0010;
    step();
    BTN_CEO_I = '0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_01) begin
      bad++; $display("FAIL bp_offer valid=%b id=%0d want 1/1", EVT_VALID, EVT_ID);
    end
    for (int w = 0; w < 10; w++) begin
      BTN_CEO_I = (w == 3) ? 4'b0010 : 4'b0000;
      step();
      total++;
      if ({EVT_VALID, EVT_ID} !== 3'b1_01) begin
        bad++; $display("FAIL bp_hold w=%0d valid=%b id=%0d want 1/1", w, EVT_VALID, EVT_ID);
      end
      total++;
      if (OVF_O !== ((w >= 3) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL bp_ovf w=%0d ovf=%b want %b", w, OVF_O, (w >= 3) ? 4'b0010 : 4'b0000);
      end
    end
    BTN_CEO_I = '0;
    EVT_READY = 1'b1;
    step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL bp_accept valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (EVT_VALID !== 1'b0) begin
        bad++; $display("FAIL bp_single c=%0d valid=%b want 0", c, EVT_VALID);
      end
    end
    total++;
    if (OVF_O !== 4'b0010) begin
      bad++; $display("FAIL bp_ovf_sticky ovf=%b want 0010", OVF_O);
    end
  endtask

  task automatic test_set_clear();
    do_reset();
    EVT_READY = 1'b1;
    BTN_CEO_I = 4'b0001;
    step();
    BTN_CEO_I = '0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_00) begin
      bad++; $display("FAIL sc_offer valid=%b id=%0d want 1/0", EVT_VALID, EVT_ID);
    end
    BTN_CEO_I = 4'b0001;
    step();
    BTN_CEO_I = '0;
    total++;
    if ({EVT_VALID, PEND_O, OVF_O} !== 9'b0_0001_0000) begin
      bad++; $display("FAIL sc_set_wins valid=%b pend=%b ovf=%b want 0/0001/0000", EVT_VALID, PEND_O, OVF_O);
    end
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_00) begin
      bad++; $display("FAIL sc_second_event valid=%b id=%0d want 1/0", EVT_VALID, EVT_ID);
    end
    step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL sc_drained valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
    EVT_READY = 1'b0;
    BTN_CEO_I = 4'b0100;
    step();
    BTN_CEO_I = '0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_10) begin
      bad++; $display("FAIL sc_offer2 valid=%b id=%0d want 1/2", EVT_VALID, EVT_ID);
    end
    BTN_CEO_I = 4'b0100;
    CLR_OVF   = 1'b1;
    step();
    BTN_CEO_I = '0;
    total++;
    if (OVF_O !== 4'b0100) begin
      bad++; $display("FAIL sc_ovf_beats_clr ovf=%b want 0100", OVF_O);
    end
    step();
    CLR_OVF = 1'b0;
    total++;
    if (OVF_O !== 4'b0000) begin
      bad++; $display("FAIL sc_clr_ovf ovf=%b want 0000", OVF_O);
    end
    EVT_READY = 1'b1;
    step(); step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL sc_final valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    EVT_READY = 1'b1;
    BTN_CEO_I = 4'b1111;
    step();
    BTN_CEO_I = '0;
    step();
    step();
    EVT_READY = 1'b0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_01) begin
      bad++; $display("FAIL rm_pre_offer valid=%b id=%0d want 1/1", EVT_VALID, EVT_ID);
    end
    #2;
    RST = 1'b0;
    #1;
    total++;
    if ({CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O} !== '0) begin
      bad++; $display("FAIL rm_async_clear outs=%b want 0", {CE_O, EVT_VALID, EVT_ID, PEND_O, OVF_O});
    end
    step(); step();
    RST = 1'b1;
    step(); step();
    total++;
    if ({EVT_VALID, PEND_O} !== 5'b0_0000) begin
      bad++; $display("FAIL rm_no_replay valid=%b pend=%b want 0/0000", EVT_VALID, PEND_O);
    end
    EVT_READY = 1'b1;
    BTN_CEO_I = 4'b1111;
    step();
    BTN_CEO_I = '0;
    step();
    total++;
    if ({EVT_VALID, EVT_ID} !== 3'b1_00) begin
      bad++; $display("FAIL rm_first_grant valid=%b id=%0d want 1/0", EVT_VALID, EVT_ID);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_single_press();
    test_round_robin();
    test_backpressure();
    test_set_clear();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
